// File: rtl/acumulador_pkg.sv
// Shared types and default sizes for the multiply-accumulate controller.
package acumulador_pkg;

  localparam int unsigned TAM_DEF   = 8;
  localparam int unsigned N_MAX_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_OP,
    FIRE,
    WAIT_MULT,
    DONE
  } estado_t;

endpackage

// File: rtl/multipli.sv
// Signed sequential multiplier: magnitude shift-add over tamano cycles, sign fixed at the end.
// S is held until the next operation; END_MULT pulses for one cycle when S is updated.
module multipli #(
  parameter int unsigned tamano = 8
) (
  input  logic                         CLOCK,
  input  logic                         RESET,
  input  logic                         START,
  input  logic signed [tamano-1:0]     A,
  input  logic signed [tamano-1:0]     B,
  output logic signed [2*tamano-1:0]   S,
  output logic                         END_MULT
);

  localparam int unsigned ProdW = 2 * tamano;
  localparam int unsigned CntW  = $clog2(tamano + 1);

  logic                busy_q, busy_d;
  logic [ProdW-1:0]    mcand_q, mcand_d;
  logic [tamano-1:0]   mplier_q, mplier_d;
  logic [ProdW-1:0]    prod_q, prod_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic [ProdW-1:0]    s_q, s_d;
  logic                end_q, end_d;

  logic [tamano-1:0]   a_mag, b_mag;
  logic [ProdW-1:0]    prod_acc;

  // The most negative operand has a magnitude that still fits as an unsigned tamano-bit value.
  assign a_mag    = A[tamano-1] ? (~A + 1'b1) : A;
  assign b_mag    = B[tamano-1] ? (~B + 1'b1) : B;
  assign prod_acc = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    busy_d   = busy_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    s_d      = s_q;
    end_d    = 1'b0;
    if (!busy_q) begin
      if (START) begin
        mcand_d  = {{tamano{1'b0}}, a_mag};
        mplier_d = b_mag;
        prod_d   = '0;
        cnt_d    = CntW'(tamano);
        neg_d    = A[tamano-1] ^ B[tamano-1];
        busy_d   = 1'b1;
      end
    end else begin
      prod_d   = prod_acc;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        busy_d = 1'b0;
        end_d  = 1'b1;
        s_d    = neg_q ? (~prod_acc + 1'b1) : prod_acc;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      busy_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      s_q      <= '0;
      end_q    <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      s_q      <= s_d;
      end_q    <= end_d;
    end
  end

  assign S        = s_q;
  assign END_MULT = end_q;

endmodule

// File: rtl/acumulador_mult.sv
// Multiply-accumulate controller: accepts LEN operand pairs, multiplies each via multipli
// and sums the signed products into a wrapping accumulator with a sticky overflow flag.
module acumulador_mult
  import acumulador_pkg::*;
#(
  parameter int unsigned tamano = TAM_DEF,
  parameter int unsigned N_MAX  = N_MAX_DEF,
  parameter int unsigned ACC_W  = 2 * tamano + 4
) (
  input  logic                           CLOCK,
  input  logic                           RESET,
  input  logic                           START,
  input  logic [$clog2(N_MAX+1)-1:0]     LEN,
  input  logic                           DATA_VALID,
  input  logic signed [tamano-1:0]       A_IN,
  input  logic signed [tamano-1:0]       B_IN,
  output logic                           DATA_READY,
  output logic signed [ACC_W-1:0]        ACC,
  output logic                           END_ACC,
  output logic                           OVF
);

  localparam int unsigned LenW  = $clog2(N_MAX + 1);
  localparam int unsigned ProdW = 2 * tamano;

  estado_t                   state_q, state_d;
  logic [LenW-1:0]           cnt_q, cnt_d;
  logic signed [tamano-1:0]  a_q, a_d, b_q, b_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      ovf_q, ovf_d;
  logic                      ready_q, ready_d;
  logic                      end_acc_q, end_acc_d;
  logic                      mult_start_q, mult_start_d;
  logic                      end_mult_q;

  logic signed [ProdW-1:0]   mult_s;
  logic                      mult_end;
  logic                      end_rise;
  logic [LenW-1:0]           len_clamped;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   sum;
  logic                      sum_ovf;

  multipli #(
    .tamano(tamano)
  ) u_multipli (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .START   (mult_start_q),
    .A       (a_q),
    .B       (b_q),
    .S       (mult_s),
    .END_MULT(mult_end)
  );

  assign len_clamped = (LEN > LenW'(N_MAX)) ? LenW'(N_MAX) : LEN;
  assign prod_ext    = ACC_W'(mult_s);
  assign sum         = acc_q + prod_ext;
  // Overflow only when both addends share a sign that the wrapped sum does not.
  assign sum_ovf     = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                       (sum[ACC_W-1] != acc_q[ACC_W-1]);
  // Edge against a registered copy so a level-style END_MULT is counted once.
  assign end_rise    = mult_end & ~end_mult_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = len_clamped;
          state_d = (len_clamped != '0) ? WAIT_OP : DONE;
        end
      end
      WAIT_OP: begin
        if (DATA_VALID) begin
          a_d     = A_IN;
          b_d     = B_IN;
          state_d = FIRE;
        end
      end
      FIRE: state_d = WAIT_MULT;
      WAIT_MULT: begin
        if (end_rise) begin
          acc_d   = sum;
          ovf_d   = ovf_q | sum_ovf;
          cnt_d   = cnt_q - LenW'(1);
          state_d = (cnt_q == LenW'(1)) ? DONE : WAIT_OP;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d      = (state_d == WAIT_OP);
    mult_start_d = (state_d == FIRE);
    end_acc_d    = (state_q == DONE);
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      ready_q      <= 1'b0;
      end_acc_q    <= 1'b0;
      mult_start_q <= 1'b0;
      end_mult_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      ovf_q        <= ovf_d;
      ready_q      <= ready_d;
      end_acc_q    <= end_acc_d;
      mult_start_q <= mult_start_d;
      end_mult_q   <= mult_end;
    end
  end

  assign DATA_READY = ready_q;
  assign ACC        = acc_q;
  assign END_ACC    = end_acc_q;
  assign OVF        = ovf_q;

endmodule

// File: tb/tb_acumulador_mult.sv
// Bench for acumulador_mult: default-width and 16-bit-accumulator instances share one stimulus
// stream and are compared against an arithmetic dot-product model.
module tb_acumulador_mult;

  localparam int unsigned TAM   = 8;
  localparam int unsigned NMAX  = 16;
  localparam int unsigned ACCW0 = 2 * TAM + 4;
  localparam int unsigned ACCW1 = 16;

  logic                     clk;
  logic                     rst_n;
  logic                     start;
  logic [4:0]               len_s;
  logic                     valid;
  logic signed [TAM-1:0]    a_in;
  logic signed [TAM-1:0]    b_in;
  logic                     ready0, ready1;
  logic signed [ACCW0-1:0]  acc0;
  logic signed [ACCW1-1:0]  acc1;
  logic                     end0, end1;
  logic                     ovf0, ovf1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_mstart = 0;
  int pa[32];
  int pb[32];

  acumulador_mult #(
    .tamano(TAM),
    .N_MAX (NMAX)
  ) u_dut (
    .CLOCK     (clk),
    .RESET     (rst_n),
    .START     (start),
    .LEN       (len_s),
    .DATA_VALID(valid),
    .A_IN      (a_in),
    .B_IN      (b_in),
    .DATA_READY(ready0),
    .ACC       (acc0),
    .END_ACC   (end0),
    .OVF       (ovf0)
  );

  acumulador_mult #(
    .tamano(TAM),
    .N_MAX (NMAX),
    .ACC_W (ACCW1)
  ) u_dut16 (
    .CLOCK     (clk),
    .RESET     (rst_n),
    .START     (start),
    .LEN       (len_s),
    .DATA_VALID(valid),
    .A_IN      (a_in),
    .B_IN      (b_in),
    .DATA_READY(ready1),
    .ACC       (acc1),
    .END_ACC   (end1),
    .OVF       (ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (u_dut.mult_start_q === 1'b1) n_mstart++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Dot product of the first n pairs, wrapped to w bits, with the sticky overflow flag.
  function automatic void model(input int n, input int w, output longint acc, output bit ovf);
    longint span, lo, hi;
    span = longint'(1) <<< w;
    hi   = (span >>> 1) - 1;
    lo   = -(span >>> 1);
    acc  = 0;
    ovf  = 1'b0;
    for (int i = 0; i < n; i++) begin
      acc += longint'(pa[i]) * longint'(pb[i]);
      if (acc > hi) begin
        acc -= span;
        ovf = 1'b1;
      end else if (acc < lo) begin
        acc += span;
        ovf = 1'b1;
      end
    end
  endfunction

  task automatic send(input int a, input int b, input int gap);
    int c;
    c = 0;
    while (!ready0 && c < 200) begin
      tick();
      c++;
    end
    if (!ready0) begin
      check("ready_timeout", ready0, 1);
      return;
    end
    if (gap > 0) begin
      repeat (gap / 2) tick();
      start = 1'b1;
      len_s = 5'd3;
      tick();
      start = 1'b0;
      repeat (gap - gap / 2) tick();
      check("stall_ready", ready0, 1);
    end
    valid = 1'b1;
    a_in  = a[TAM-1:0];
    b_in  = b[TAM-1:0];
    tick();
    valid = 1'b0;
    a_in  = TAM'($urandom);
    b_in  = TAM'($urandom);
    check("ready_drop", ready0, 0);
  endtask

  task automatic run(input string tag, input int len, input int gap_at, input int gap_len);
    int     n, c;
    longint e0, e1;
    bit     o0, o1;
    n = (len > NMAX) ? NMAX : len;
    start = 1'b1;
    len_s = len[4:0];
    tick();
    start = 1'b0;
    check({tag, "_acc_clr"}, acc0, 0);
    check({tag, "_ovf_clr"}, ovf1, 0);
    if (n == 0) begin
      check({tag, "_len0_ready"}, ready0, 0);
      check({tag, "_len0_early"}, end0, 0);
      tick();
      check({tag, "_len0_end"}, end0, 1);
    end else begin
      for (int i = 0; i < n; i++) send(pa[i], pb[i], (i == gap_at) ? gap_len : 0);
      c = 0;
      while (!end0 && c < 200) begin
        tick();
        c++;
      end
      check({tag, "_end_seen"}, end0, 1);
    end
    model(n, ACCW0, e0, o0);
    model(n, ACCW1, e1, o1);
    check({tag, "_acc"}, acc0, e0);
    check({tag, "_ovf"}, ovf0, o0);
    check({tag, "_acc16"}, acc1, e1);
    check({tag, "_ovf16"}, ovf1, o1);
    check({tag, "_end16"}, end1, 1);
    tick();
    check({tag, "_end_pulse"}, end0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    len_s = '0;
    valid = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) tick();
    check("rst_acc", acc0, 0);
    check("rst_end", end0, 0);
    check("rst_ovf", ovf0, 0);
    check("rst_ready", ready0, 0);
    rst_n = 1'b1;
    tick();

    pa[0] = 3; pb[0] = 5;
    run("len1", 1, -1, 0);

    pa[0] = -1; pb[0] = 2; pa[1] = -128; pb[1] = 2; pa[2] = 10; pb[2] = 12;
    n_mstart = 0;
    run("len3", 3, -1, 0);
    check("len3_acc_lit", acc0, -138);
    check("len3_mstarts", n_mstart, 3);

    run("len0", 0, -1, 0);

    for (int i = 0; i < 3; i++) begin
      pa[i] = -128;
      pb[i] = -128;
    end
    run("wrap", 3, -1, 0);
    check("wrap_acc16_lit", acc1, -16384);
    check("wrap_ovf16_lit", ovf1, 1);

    pa[0] = 4; pb[0] = 4; pa[1] = 7; pb[1] = -9;
    n_mstart = 0;
    run("stall", 2, 1, 20);
    check("stall_acc_lit", acc0, -47);
    check("stall_mstarts", n_mstart, 2);

    // Reset lands during the second multiplication of a four-term run.
    pa[0] = 10; pb[0] = 10;
    start = 1'b1;
    len_s = 5'd4;
    tick();
    start = 1'b0;
    send(10, 10, 0);
    send(3, 3, 0);
    tick();
    tick();
    check("pre_reset_acc", acc0, 100);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_acc", acc0, 0);
    check("mid_rst_end", end0, 0);
    check("mid_rst_ready", ready0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    pa[0] = 105; pb[0] = -71;
    run("post_rst", 1, -1, 0);
    check("post_rst_acc_lit", acc0, -7455);

    for (int r = 0; r < 10; r++) begin
      int l;
      l = int'($urandom_range(0, 20));
      for (int i = 0; i < 32; i++) begin
        pa[i] = int'($urandom_range(0, 255)) - 128;
        pb[i] = int'($urandom_range(0, 255)) - 128;
      end
      run("rand", l, int'($urandom_range(0, 3)),
          int'($urandom_range(0, 1)) * int'($urandom_range(1, 6)));
    end

    for (int i = 0; i < 16; i++) begin
      pa[i] = -128;
      pb[i] = -128;
    end
    run("clamp", 31, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
